game_director: RTL and testbench

Top-level game sequencer for the brick-breaker design. Sits above the ball/brick engine and decides when the engine is reset (brick field reloaded), when a ball is launched, and how fast the engine steps. Tracks lives, a 4-digit BCD score, the level and the bricks remaining, and drives the game-over indication for the display path.

---
 rtl/game_director.sv | 239 +++++++++++++++++++++++
 tb/tb_game_director.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_director.sv
// game_director: top-level sequencer for the brick-breaker game.
// Decides when the ball engine is held in reset, when a ball is launched and
// how fast the engine steps. It tracks lives, a 4-digit BCD score, the level
// and the bricks remaining, and raises game_over for the display path.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_start    debounced start/serve button (rising edge used)
//   ball_lost    1-cycle pulse: ball missed the paddle
//   brick_hit    1-cycle pulse: a brick was struck
//   brick_clear  1-cycle pulse: a brick reached strength 0
//   ball_rst     active-low reset to the ball engine (low reloads bricks)
//   ball_start   1-cycle launch pulse
//   step_period  engine step period in clk cycles
//   lives        lives remaining
//   score        four BCD digits, [15:12] = thousands
//   level        current level 1..15
//   game_over    high while in OVER
//   state        current state code
//
// Optional feature: define AUTO_SERVE_EN to launch the ball automatically
// after SERVE_DELAY cycles in SERVE when no start edge arrives.
//
// state | meaning
// IDLE  | power-up, waiting for the first start edge
// LOAD  | ball engine held in reset for 2 cycles, brick field reloaded
// SERVE | waiting for a start edge to launch the ball
// PLAY  | ball in play, counting hits and cleared bricks
// LOST  | one cycle: take a life, then serve again or game over
// CLEAR | one cycle: level up and speed up, then reload
// OVER  | game finished, final field shown until a start edge
module game_director #(
  parameter int LIVES       = 3,
  parameter int BRICKS      = 64,
  parameter int BASE_PERIOD = 100000,
  parameter int PERIOD_STEP = 10000,
  parameter int MIN_PERIOD  = 40000,
  parameter int SERVE_DELAY = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        ball_lost,
  input  logic        brick_hit,
  input  logic        brick_clear,
  output logic        ball_rst,
  output logic        ball_start,
  output logic [31:0] step_period,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [3:0]  level,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SERVE = 3'd2,
    S_PLAY  = 3'd3,
    S_LOST  = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [6:0]  BRICKS_INIT = 7'(BRICKS);
  localparam logic [31:0] BASE_P = 32'(BASE_PERIOD);
  localparam logic [31:0] STEP_P = 32'(PERIOD_STEP);
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
  // Subtracting only when period >= MIN+STEP keeps the result >= MIN and
  // can never wrap below zero.
  localparam logic [31:0] FLOOR_THR = 32'(MIN_PERIOD + PERIOD_STEP);

  if (LIVES < 1 || LIVES > 3 || BRICKS < 1 || BRICKS > 127 ||
      SERVE_DELAY < 1 || BASE_PERIOD < MIN_PERIOD) begin : g_param_check
    $error("game_director: parameter out of range");
  end

  state_t      state_q, state_d;
  logic        btn_q;
  logic        start_edge;
  logic        auto_fire;
  logic        load_cnt_q, load_cnt_d;
  logic [6:0]  bricks_q, bricks_d;
  logic [1:0]  lives_d;
  logic [15:0] score_d;
  logic [3:0]  level_d;
  logic [31:0] period_d;
  logic        ball_start_d;

  assign start_edge = btn_start & ~btn_q;

  // BCD increment with ripple carry; 9999 is sticky.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

`ifdef AUTO_SERVE_EN
  logic [31:0] serve_cnt_q, serve_cnt_d;

  assign auto_fire = (state_q == S_SERVE) && (serve_cnt_q == 32'd0);

  always_comb begin
    serve_cnt_d = serve_cnt_q;
    if (state_d == S_SERVE && state_q != S_SERVE) begin
      serve_cnt_d = 32'(SERVE_DELAY - 1);
    end else if (state_q == S_SERVE && serve_cnt_q != 32'd0) begin
      serve_cnt_d = serve_cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serve_cnt_q <= 32'd0;
    end else begin
      serve_cnt_q <= serve_cnt_d;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    bricks_d     = bricks_q;
    lives_d      = lives;
    score_d      = score;
    level_d      = level;
    period_d     = step_period;
    ball_start_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d    = S_LOAD;
          load_cnt_d = 1'b1;
          lives_d    = LIVES_INIT;
          score_d    = 16'h0000;
          level_d    = 4'd1;
          period_d   = BASE_P;
        end
      end
      S_LOAD: begin
        bricks_d = BRICKS_INIT;
        if (load_cnt_q) begin
          load_cnt_d = 1'b0;
        end else begin
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (start_edge || auto_fire) begin
          ball_start_d = 1'b1;
          state_d      = S_PLAY;
        end
      end
      S_PLAY: begin
        if (brick_hit) begin
          score_d = bcd_inc(score);
        end
        if (brick_clear && bricks_q != 7'd0) begin
          bricks_d = bricks_q - 7'd1;
        end
        // Clearing the last brick beats a simultaneous ball loss.
        if (brick_clear && bricks_q == 7'd1) begin
          state_d = S_CLEAR;
        end else if (ball_lost) begin
          state_d = S_LOST;
        end
      end
      S_LOST: begin
        if (lives <= 2'd1) begin
          lives_d = 2'd0;
          state_d = S_OVER;
        end else begin
          lives_d = lives - 2'd1;
          state_d = S_SERVE;
        end
      end
      S_CLEAR: begin
        level_d    = (level == 4'd15) ? 4'd15 : level + 4'd1;
        period_d   = (step_period >= FLOOR_THR) ? step_period - STEP_P : MIN_P;
        state_d    = S_LOAD;
        load_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      btn_q       <= 1'b0;
      load_cnt_q  <= 1'b0;
      bricks_q    <= 7'd0;
      lives       <= 2'd0;
      score       <= 16'h0000;
      level       <= 4'd1;
      step_period <= BASE_P;
      ball_start  <= 1'b0;
      ball_rst    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_start;
      load_cnt_q  <= load_cnt_d;
      bricks_q    <= bricks_d;
      lives       <= lives_d;
      score       <= score_d;
      level       <= level_d;
      step_period <= period_d;
      ball_start  <= ball_start_d;
      // Decoded from the next state so the outputs line up with state.
      ball_rst    <= (state_d != S_IDLE) && (state_d != S_LOAD);
      game_over   <= (state_d == S_OVER);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_director.sv
module tb_game_director;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        ball_lost = 1'b0;
  logic        brick_hit = 1'b0;
  logic        brick_clear = 1'b0;
  logic        ball_rst;
  logic        ball_start;
  logic [31:0] step_period;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [3:0]  level;
  logic        game_over;
  logic [2:0]  state;

  game_director #(
    .LIVES(3), .BRICKS(2), .BASE_PERIOD(100000), .PERIOD_STEP(10000),
    .MIN_PERIOD(40000), .SERVE_DELAY(10)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .ball_lost(ball_lost),
    .brick_hit(brick_hit), .brick_clear(brick_clear), .ball_rst(ball_rst),
    .ball_start(ball_start), .step_period(step_period), .lives(lives),
    .score(score), .level(level), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        btn, lost, hit, clr;
    logic [2:0]  st;
    logic [1:0]  lv;
    logic [15:0] sc;
    logic [3:0]  lvl;
    logic [31:0] per;
    logic        brst, bst, go;
  } vec_t;

  localparam int NV = 26;
  localparam logic [31:0] P0 = 32'd100000;
  localparam logic [31:0] P1 = 32'd90000;

  vec_t vecs[NV];
  vec_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic b, l, h, c, input logic [2:0] st,
                              input logic [1:0] lv, input logic [15:0] sc,
                              input logic [3:0] lvl, input logic [31:0] per,
                              input logic brst, bst, go);
    vec_t v;
    v.btn = b; v.lost = l; v.hit = h; v.clr = c;
    v.st = st; v.lv = lv; v.sc = sc; v.lvl = lvl; v.per = per;
    v.brst = brst; v.bst = bst; v.go = go;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check("wait_state", 32'(state), 32'(s));
  endtask

  task automatic serve();
    btn_start = 1'b1;
    tick();
    check("serve_pulse", 32'(ball_start), 32'd1);
    check("serve_play", 32'(state), 32'd3);
    tick();
    check("serve_single", 32'(ball_start), 32'd0);
    btn_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   exp_per;
    int   n;
    //               btn lst hit clr st  lv  score    lvl per brst bst go
    vecs[0]  = mk(0, 0, 0, 0, 3'd0, 2'd0, 16'h0000, 4'd1, P0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 3'd1, 2'd3, 16'h0000, 4'd1, P0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 3'd1, 2'd3, 16'h0000, 4'd1, P0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 3'd2, 2'd3, 16'h0000, 4'd1, P0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 3'd2, 2'd3, 16'h0000, 4'd1, P0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 3'd2, 2'd3, 16'h0000, 4'd1, P0, 1, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 3'd3, 2'd3, 16'h0000, 4'd1, P0, 1, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 3'd3, 2'd3, 16'h0000, 4'd1, P0, 1, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 3'd3, 2'd3, 16'h0001, 4'd1, P0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 1, 1, 3'd3, 2'd3, 16'h0002, 4'd1, P0, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 3'd4, 2'd3, 16'h0002, 4'd1, P0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 3'd2, 2'd2, 16'h0002, 4'd1, P0, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 3'd2, 2'd2, 16'h0002, 4'd1, P0, 1, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 3'd3, 2'd2, 16'h0002, 4'd1, P0, 1, 1, 0);
    vecs[14] = mk(0, 1, 0, 1, 3'd5, 2'd2, 16'h0002, 4'd1, P0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 3'd1, 2'd2, 16'h0002, 4'd2, P1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 3'd1, 2'd2, 16'h0002, 4'd2, P1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 3'd2, 2'd2, 16'h0002, 4'd2, P1, 1, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 3'd3, 2'd2, 16'h0002, 4'd2, P1, 1, 1, 0);
    vecs[19] = mk(0, 1, 0, 0, 3'd4, 2'd2, 16'h0002, 4'd2, P1, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 3'd2, 2'd1, 16'h0002, 4'd2, P1, 1, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 3'd3, 2'd1, 16'h0002, 4'd2, P1, 1, 1, 0);
    vecs[22] = mk(0, 1, 0, 0, 3'd4, 2'd1, 16'h0002, 4'd2, P1, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 3'd6, 2'd0, 16'h0002, 4'd2, P1, 1, 0, 1);
    vecs[24] = mk(0, 1, 1, 1, 3'd6, 2'd0, 16'h0002, 4'd2, P1, 1, 0, 1);
    vecs[25] = mk(1, 0, 0, 0, 3'd1, 2'd3, 16'h0000, 4'd1, P0, 0, 0, 0);

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ball_rst", 32'(ball_rst), 32'd0);
    check("rst_ball_start", 32'(ball_start), 32'd0);
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_level", 32'(level), 32'd1);
    check("rst_period", step_period, P0);
    check("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      btn_start   = vecs[i].btn;
      ball_lost   = vecs[i].lost;
      brick_hit   = vecs[i].hit;
      brick_clear = vecs[i].clr;
      q.push_back(vecs[i]);
      tick();
      e = q.pop_front();
      check($sformatf("v%0d_state", i), 32'(state), 32'(e.st));
      check($sformatf("v%0d_lives", i), 32'(lives), 32'(e.lv));
      check($sformatf("v%0d_score", i), 32'(score), 32'(e.sc));
      check($sformatf("v%0d_level", i), 32'(level), 32'(e.lvl));
      check($sformatf("v%0d_period", i), step_period, e.per);
      check($sformatf("v%0d_ball_rst", i), 32'(ball_rst), 32'(e.brst));
      check($sformatf("v%0d_ball_start", i), 32'(ball_start), 32'(e.bst));
      check($sformatf("v%0d_game_over", i), 32'(game_over), 32'(e.go));
    end
    btn_start = 1'b0; ball_lost = 1'b0; brick_hit = 1'b0; brick_clear = 1'b0;

    // Twelve hits exercise the units-to-tens carry.
    wait_state(3'd2, 10);
    serve();
    brick_hit = 1'b1;
    repeat (12) tick();
    brick_hit = 1'b0;
    tick();
    check("score_12", 32'(score), 32'h0012);

    // Clear levels 1..7; period drops by 10000 and floors at 40000.
    exp_per = 100000;
    for (int lv = 2; lv <= 8; lv++) begin
      brick_clear = 1'b1;
      tick();
      tick();
      brick_clear = 1'b0;
      check("clear_state", 32'(state), 32'd5);
      tick();
      exp_per = (exp_per - 10000 < 40000) ? 40000 : exp_per - 10000;
      check($sformatf("lvl%0d_level", lv), 32'(level), 32'(lv));
      check($sformatf("lvl%0d_period", lv), step_period, 32'(exp_per));
      check($sformatf("lvl%0d_lives", lv), 32'(lives), 32'd3);
      check($sformatf("lvl%0d_score", lv), 32'(score), 32'h0012);
      wait_state(3'd2, 10);
      serve();
    end

    // Score saturation at 9999.
    brick_hit = 1'b1;
    repeat (10000) tick();
    brick_hit = 1'b0;
    tick();
    check("score_sat", 32'(score), 32'h9999);
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    tick();
    check("score_sat_hold", 32'(score), 32'h9999);

    // Lose a ball and observe SERVE with no button.
    ball_lost = 1'b1;
    tick();
    ball_lost = 1'b0;
    check("lost_state", 32'(state), 32'd4);
    tick();
    check("serve_again", 32'(state), 32'd2);
    check("serve_lives", 32'(lives), 32'd2);
    n = 0;
`ifdef AUTO_SERVE_EN
    while (ball_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("auto_serve_cycles", 32'(n), 32'd10);
    check("auto_serve_state", 32'(state), 32'd3);
`else
    repeat (1000) begin
      tick();
      if (ball_start === 1'b1) n++;
    end
    check("no_auto_serve", 32'(n), 32'd0);
    check("no_auto_state", 32'(state), 32'd2);
`endif

    // Asynchronous reset mid-game, between clock edges.
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_ball_rst", 32'(ball_rst), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_lives", 32'(lives), 32'd0);
    check("async_rst_score", 32'(score), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
